bitwise_logic_pipe: RTL
=======================

Name: bitwise_logic_pipe

Overview:
Parametrised, pipelined successor to the fixed 32-bit gate-level OR unit. Computes one of four bitwise operations (AND/OR/XOR/NOR) on two WIDTH-bit operands. Produces a registered zero flag alongside each result. Operates through STAGES elastic pipeline stages with valid/ready handshakes on both sides, and serves as the logic slice of the multi-cycle/pipelined ALU datapath.

Parameters:
WIDTH, 32, operand and result width in bits (legal range 1..64)
STAGES, 2, number of register stages between input and output (legal range 1..4)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of all in-flight operations
in_valid  input  1  operand beat offered
in_ready  output  1  unit accepts a beat this cycle
op  input  2  operation select: 00 AND, 01 OR, 10 XOR, 11 NOR
input1  input  WIDTH  operand A
input2  input  WIDTH  operand B
out_valid  output  1  result beat available
out_ready  input  1  consumer accepts the result beat
result  output  WIDTH  bitwise result
zero  output  1  high when result is all zeros

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset: every stage valid bit clears to 0, and every stage data and flag register clears to 0. Consequently out_valid=0, result=0, zero=0. in_ready is 1 once reset is released. Asserting rst_n low mid-operation discards all in-flight beats immediately.
- Input transfer occurs when in_valid & in_ready at the rising edge of clk.
- Output transfer occurs when out_valid & out_ready at the rising edge of clk.
- Operation is computed combinationally from input1/input2/op and captured into stage 0. Later stages only forward data.
- zero is computed on the operation result before stage 0 and travels with it.
- Elastic pipeline: stage k loads when it is empty or its content moves onward this cycle.
  - Last stage moves when out_ready=1.
  - in_ready = !valid[0] | advance[0]. This combinational ready chain is accepted.
- Latency: with out_ready held high, a beat accepted at edge N appears with out_valid=1 after edge N+STAGES-1, i.e. STAGES cycles from in_valid to consumption.
- Throughput: 1 beat/cycle with no backpressure.
- Backpressure: when out_ready=0 and all stages are full, in_ready=0. result, zero and out_valid hold stable until the transfer.
- Stalled beats: no beat is dropped or duplicated. Order is preserved.
- Bubbles: gaps in in_valid propagate as bubbles and are compressed when downstream stalls.
- Simultaneous accept and emit when full with out_ready=1: the pipeline shifts, and a new input is accepted in the same cycle.
- flush: the next edge clears all valid bits; data registers need not clear. An input presented in the flush cycle is discarded, and in_ready is forced to 0 during flush. flush has priority over every transfer.
- NOR at WIDTH=1 is plain single-bit NOR. No width extension anywhere; all operations are exactly WIDTH bits.
- op values are exhaustive, so there is no illegal encoding.

Decomposition:
- Shared package (alu_pkg): op encoding constants LOGIC_AND=2'b00, LOGIC_OR=2'b01, LOGIC_XOR=2'b10, LOGIC_NOR=2'b11, and the logic_op_t 2-bit typedef. These are reused by the ALU control decoder.
- One sub-module, elastic_stage: a single valid/ready register slice of parameterised payload width (WIDTH+1, carrying data plus zero). It is instantiated STAGES times via generate.
- Top level: the combinational op mux, zero detect, and flush fan-out.

Test Plan:
- Reset: hold rst_n=0 with random inputs. Expect out_valid=0, result=0, zero=0, in_ready=1 after release.
- Op sweep, WIDTH=32, STAGES=2, out_ready=1: input1=0xF0F0_1234, input2=0x0FF0_00FF.
  - AND expects 0x00F0_0034.
  - OR expects 0xFFF0_12FF.
  - XOR expects 0xFF00_12CB.
  - NOR expects 0x000F_ED00.
  - Each appears 2 cycles after acceptance, with zero=0.
- Zero flag: AND input1=0xAAAA_AAAA with input2=0x5555_5555. Expect result=0, zero=1.
- Backpressure: stream 6 beats with out_ready=0 for 5 cycles. Expect in_ready to drop after 2 beats accepted, and out_valid and result stable. Then release and expect all 6 results in order with no loss or duplicates.
- Flush: with 2 beats in flight, pulse flush for 1 cycle. Expect out_valid=0 next cycle, and those beats never appear. A beat offered during the flush cycle is not accepted.
- Async reset mid-stream: drop rst_n between edges with the pipeline full. Expect out_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU logic-op encodings
//
// Purpose: operation select encoding for the logic slice. The ALU control
// decoder imports the same constants, so any change here moves both.
// Ports: none (package).
package alu_pkg;

  typedef enum logic [1:0] {
    LOGIC_AND = 2'b00,
    LOGIC_OR  = 2'b01,
    LOGIC_XOR = 2'b10,
    LOGIC_NOR = 2'b11
  } logic_op_t;

  localparam int LOGIC_OP_W = 2;

endpackage : alu_pkg

// File: rtl/elastic_stage.sv
// rtl/elastic_stage.sv - single valid/ready register slice
//
// Purpose: one elastic pipeline register. It accepts a new beat whenever it
// is empty or its current beat leaves this cycle, so a chain of these runs
// at one beat per cycle and compresses bubbles under backpressure.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous clear of the held beat (valid only)
//   s_tvalid/s_tready   upstream handshake
//   s_tdata             upstream payload
//   m_tvalid/m_tready   downstream handshake
//   m_tdata             downstream payload (registered)
module elastic_stage #(
  parameter int PAYLOAD_W = 33
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  input  logic [PAYLOAD_W-1:0] s_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [PAYLOAD_W-1:0] m_tdata
);

  logic                 valid_q, valid_d;
  logic [PAYLOAD_W-1:0] data_q, data_d;
  logic                 advance;
  logic                 load;

  // The held beat leaves when downstream takes it; the slot is then free
  // for a new beat in the same cycle.
  assign advance  = valid_q & m_tready;
  assign s_tready = ~valid_q | advance;
  assign load     = s_tvalid & s_tready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      data_d = s_tdata;
    end
    // Flush wins over every transfer; data may keep stale content.
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
    end else if (advance) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign m_tvalid = valid_q;
  assign m_tdata  = data_q;

endmodule : elastic_stage

// File: rtl/bitwise_logic_pipe.sv
// rtl/bitwise_logic_pipe.sv - pipelined bitwise AND/OR/XOR/NOR unit
//
// Purpose: logic slice of the pipelined ALU. The operation and zero flag are
// computed combinationally from the inputs and captured together into the
// first elastic stage; later stages only forward {zero, result}.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous clear of all in-flight beats
//   in_valid/in_ready   operand handshake (in_ready forced low during flush)
//   op                  00 AND, 01 OR, 10 XOR, 11 NOR
//   input1, input2      WIDTH-bit operands
//   out_valid/out_ready result handshake
//   result              WIDTH-bit result
//   zero                high when result is all zeros
import alu_pkg::*;

module bitwise_logic_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  logic_op_t        op_sel;
  logic [WIDTH-1:0] res_c;
  logic             zero_c;

  // Index k is the input side of stage k; index STAGES is the output side.
  logic [STAGES:0]  stg_valid;
  logic [STAGES:0]  stg_ready;
  logic [WIDTH:0]   stg_data [STAGES+1];

  assign op_sel = logic_op_t'(op);

  always_comb begin
    res_c = '0;
    case (op_sel)
      LOGIC_AND: res_c = input1 & input2;
      LOGIC_OR:  res_c = input1 | input2;
      LOGIC_XOR: res_c = input1 ^ input2;
      LOGIC_NOR: res_c = ~(input1 | input2);
      default:   res_c = '0;
    endcase
    zero_c = (res_c == '0);
  end

  // A beat offered during flush is discarded: it never reaches stage 0.
  assign stg_valid[0]      = in_valid & ~flush;
  assign stg_data[0]       = {zero_c, res_c};
  assign stg_ready[STAGES] = out_ready;
  assign in_ready          = stg_ready[0] & ~flush;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    elastic_stage #(
      .PAYLOAD_W (WIDTH + 1)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .s_tvalid (stg_valid[k]),
      .s_tready (stg_ready[k]),
      .s_tdata  (stg_data[k]),
      .m_tvalid (stg_valid[k+1]),
      .m_tready (stg_ready[k+1]),
      .m_tdata  (stg_data[k+1])
    );
  end

  assign out_valid = stg_valid[STAGES];
  assign result    = stg_data[STAGES][WIDTH-1:0];
  assign zero      = stg_data[STAGES][WIDTH];

endmodule : bitwise_logic_pipe
